wb_bus_arbiter: RTL and testbench

- Round-robin arbiter that shares one 32-bit, 8-source writeback bus between eight requesters (ALU, shifter, load unit, multiplier, etc.).
- Each cycle it picks one pending requester and drives the 3-bit select of an 8:1 32-bit mux.
- It captures the selected word into a single-entry output register, then presents that register to the consumer with a valid/ready handshake.
- It sits between the execution units and the register-file write port.

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/mux8to1B32.sv | 35 +++
 rtl/rr_pick8.sv | 44 ++++
 rtl/wb_bus_arbiter.sv | 118 +++++++++++
 tb/tb_wb_bus_arbiter.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared definitions for the writeback bus arbiter.
//   NSRC  : number of requesters sharing the bus (fixed at 8)
//   SEL_W : width of the source index / mux select
//   WIDTH : width of every source word and of the bus
//   src_idx_t : type of a requester index
package wb_arb_pkg;

    localparam int unsigned NSRC  = 32'd8;
    localparam int unsigned SEL_W = 32'd3;
    localparam int unsigned WIDTH = 32'd32;

    typedef logic [SEL_W-1:0] src_idx_t;

endpackage

// File: rtl/mux8to1B32.sv
// 8:1 multiplexer, 32 bits wide.
//   C2,C1,C0 : select bits, {C2,C1,C0} is the index of the chosen input
//   D0..D7   : data inputs
//   Y        : selected data
module mux8to1B32 (
    input  logic        C2,
    input  logic        C1,
    input  logic        C0,
    input  logic [31:0] D0,
    input  logic [31:0] D1,
    input  logic [31:0] D2,
    input  logic [31:0] D3,
    input  logic [31:0] D4,
    input  logic [31:0] D5,
    input  logic [31:0] D6,
    input  logic [31:0] D7,
    output logic [31:0] Y
);

    // Select one of the eight inputs.
    always_comb begin
        case ({C2, C1, C0})
            3'd0:    Y = D0;
            3'd1:    Y = D1;
            3'd2:    Y = D2;
            3'd3:    Y = D3;
            3'd4:    Y = D4;
            3'd5:    Y = D5;
            3'd6:    Y = D6;
            3'd7:    Y = D7;
            default: Y = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/rr_pick8.sv
// Round-robin pick among eight requesters.
//   req_i    : request vector
//   ptr_i    : index with highest priority this cycle
//   winner_o : first requester found scanning ptr_i, ptr_i+1, ... mod 8
//   any_o    : at least one request is pending
module rr_pick8
    import wb_arb_pkg::*;
(
    input  logic [7:0] req_i,
    input  src_idx_t   ptr_i,
    output src_idx_t   winner_o,
    output logic       any_o
);

    // Offset of the lowest set bit; 0 when the vector is empty.
    function automatic src_idx_t first_set8(input logic [7:0] v);
        src_idx_t idx;
        casez (v)
            8'b???????1: idx = 3'd0;
            8'b??????10: idx = 3'd1;
            8'b?????100: idx = 3'd2;
            8'b????1000: idx = 3'd3;
            8'b???10000: idx = 3'd4;
            8'b??100000: idx = 3'd5;
            8'b?1000000: idx = 3'd6;
            8'b10000000: idx = 3'd7;
            default:     idx = 3'd0;
        endcase
        return idx;
    endfunction

    logic [7:0] rot_s;
    src_idx_t   offs_s;

    // Rotate so the pointer position lands on bit 0, then priority-encode;
    // the 3-bit add wraps the offset back to an absolute index.
    always_comb begin
        rot_s    = (req_i >> ptr_i) | (req_i << (4'd8 - {1'b0, ptr_i}));
        offs_s   = first_set8(rot_s);
        winner_o = ptr_i + offs_s;
        any_o    = |req_i;
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Round-robin arbiter for an 8-source, 32-bit writeback bus.
//   clk       : rising-edge clock
//   reset_n   : synchronous active-low reset
//   req       : per-requester pending flag
//   data_i    : packed source words, source i at [32*i+31:32*i]
//   gnt       : one-hot grant, high in the cycle the word is captured
//   sel       : mux select = index of the current winner
//   bus_valid : output register holds a word
//   bus_data  : captured word
//   bus_src   : index of the source of bus_data
//   bus_ready : consumer accepts bus_data this cycle
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned WIDTH = wb_arb_pkg::WIDTH,
    parameter int unsigned NSRC  = wb_arb_pkg::NSRC
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NSRC-1:0]       req,
    input  logic [NSRC*WIDTH-1:0] data_i,
    output logic [NSRC-1:0]       gnt,
    output logic [2:0]            sel,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      bus_data,
    output logic [2:0]            bus_src,
    input  logic                  bus_ready
);

    src_idx_t         rr_ptr_q, rr_ptr_d;
    logic             bus_valid_q, bus_valid_d;
    logic [WIDTH-1:0] bus_data_q, bus_data_d;
    src_idx_t         bus_src_q, bus_src_d;

    src_idx_t         winner_s;
    logic             any_s;
    logic             load_en_s;
    logic             grant_s;
    logic [WIDTH-1:0] mux_y_s;

    rr_pick8 u_pick (
        .req_i    (req),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner_s),
        .any_o    (any_s)
    );

    mux8to1B32 u_mux (
        .C2 (sel[2]),
        .C1 (sel[1]),
        .C0 (sel[0]),
        .D0 (data_i[WIDTH*0 +: WIDTH]),
        .D1 (data_i[WIDTH*1 +: WIDTH]),
        .D2 (data_i[WIDTH*2 +: WIDTH]),
        .D3 (data_i[WIDTH*3 +: WIDTH]),
        .D4 (data_i[WIDTH*4 +: WIDTH]),
        .D5 (data_i[WIDTH*5 +: WIDTH]),
        .D6 (data_i[WIDTH*6 +: WIDTH]),
        .D7 (data_i[WIDTH*7 +: WIDTH]),
        .Y  (mux_y_s)
    );

    // The output slot can be (re)loaded when empty or being drained this
    // cycle; reset suppresses any grant so nothing is lost silently.
    always_comb begin
        load_en_s = !bus_valid_q || bus_ready;
        grant_s   = reset_n && load_en_s && any_s;
        if (grant_s) begin
            gnt = 8'b0000_0001 << winner_s;
            sel = winner_s;
        end else begin
            gnt = 8'h00;
            sel = 3'd0;
        end
    end

    // Next state of the output register and the round-robin pointer.
    always_comb begin
        bus_valid_d = bus_valid_q;
        bus_data_d  = bus_data_q;
        bus_src_d   = bus_src_q;
        rr_ptr_d    = rr_ptr_q;
        if (load_en_s) begin
            if (any_s) begin
                bus_valid_d = 1'b1;
                bus_data_d  = mux_y_s;
                bus_src_d   = winner_s;
                rr_ptr_d    = winner_s + 3'd1;
            end else begin
                // Drained with nothing new: data/src keep their last values.
                bus_valid_d = 1'b0;
            end
        end else begin
            // Stalled by the consumer: everything holds.
            bus_valid_d = bus_valid_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus_valid_q <= 1'b0;
            bus_data_q  <= '0;
            bus_src_q   <= 3'd0;
            rr_ptr_q    <= 3'd0;
        end else begin
            bus_valid_q <= bus_valid_d;
            bus_data_q  <= bus_data_d;
            bus_src_q   <= bus_src_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus_valid = bus_valid_q;
    assign bus_data  = bus_data_q;
    assign bus_src   = bus_src_q;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

    logic         clk;
    logic         reset_n;
    logic [7:0]   req;
    logic [255:0] data_i;
    logic [7:0]   gnt;
    logic [2:0]   sel;
    logic         bus_valid;
    logic [31:0]  bus_data;
    logic [2:0]   bus_src;
    logic         bus_ready;

    int n_checks = 0;
    int n_fail   = 0;

    wb_bus_arbiter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .data_i    (data_i),
        .gnt       (gnt),
        .sel       (sel),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_src   (bus_src),
        .bus_ready (bus_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic        m_init = 1'b0;
    logic        m_valid;
    logic [31:0] m_data;
    logic [2:0]  m_src;
    logic [2:0]  m_ptr;

    // Scan ptr, ptr+1, ... mod 8; returns {found, index}.
    function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] p);
        for (int k = 0; k < 8; k++) begin
            int idx;
            idx = (int'(p) + k) % 8;
            if (r[idx]) return {1'b1, 3'(idx)};
        end
        return 4'b0000;
    endfunction

    always @(posedge clk) begin
        logic [3:0] w;
        w = pick(req, m_ptr);
        if (!reset_n) begin
            m_init  <= 1'b1;
            m_valid <= 1'b0;
            m_data  <= 32'h0;
            m_src   <= 3'd0;
            m_ptr   <= 3'd0;
        end else if (m_init && (!m_valid || bus_ready)) begin
            if (w[3]) begin
                m_valid <= 1'b1;
                m_data  <= data_i[32*w[2:0] +: 32];
                m_src   <= w[2:0];
                m_ptr   <= w[2:0] + 3'd1;
            end else begin
                m_valid <= 1'b0;
            end
        end
    end

    // Compare every cycle once the model is initialised.
    always @(negedge clk) begin
        logic [3:0] w;
        logic [7:0] eg;
        logic [2:0] es;
        if (m_init) begin
            w  = pick(req, m_ptr);
            eg = 8'h00;
            es = 3'd0;
            if (reset_n && (!m_valid || bus_ready) && w[3]) begin
                eg = 8'h01 << w[2:0];
                es = w[2:0];
            end
            chk("model_gnt", {24'd0, gnt}, {24'd0, eg});
            chk("model_sel", {29'd0, sel}, {29'd0, es});
            chk("model_valid", {31'd0, bus_valid}, {31'd0, m_valid});
            chk("model_data", bus_data, m_data);
            chk("model_src", {29'd0, bus_src}, {29'd0, m_src});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        req       = 8'h00;
        data_i    = '0;
        bus_ready = 1'b1;
        cyc();
        cyc();
        chk("rst_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_data", bus_data, 32'd0);
        chk("rst_src", {29'd0, bus_src}, 32'd0);
        chk("rst_gnt", {24'd0, gnt}, 32'd0);

        // Single request
        reset_n = 1'b1;
        req     = 8'b0000_0100;
        data_i[32*2 +: 32] = 32'hDEAD_BEEF;
        mid();
        chk("t1_gnt", {24'd0, gnt}, 32'h04);
        chk("t1_sel", {29'd0, sel}, 32'd2);
        cyc();
        req = 8'h00;
        chk("t1_valid", {31'd0, bus_valid}, 32'd1);
        chk("t1_data", bus_data, 32'hDEAD_BEEF);
        chk("t1_src", {29'd0, bus_src}, 32'd2);
        chk("t1_ptr", {29'd0, dut.rr_ptr_q}, 32'd3);

        // Restart from pointer 0, then everyone requests
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) data_i[32*i +: 32] = 32'h100 + i;
        req = 8'hFF;
        for (int k = 0; k < 9; k++) begin
            mid();
            chk("t2_gnt", {24'd0, gnt}, 32'd1 << (k % 8));
            chk("t2_sel", {29'd0, sel}, k % 8);
            cyc();
            chk("t2_valid", {31'd0, bus_valid}, 32'd1);
            chk("t2_data", bus_data, 32'h100 + (k % 8));
        end

        // Backpressure: last winner 0, hold 3 cycles
        bus_ready = 1'b0;
        req       = 8'h81;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("t3_gnt_stall", {24'd0, gnt}, 32'd0);
            cyc();
            chk("t3_data_hold", bus_data, 32'h100);
            chk("t3_src_hold", {29'd0, bus_src}, 32'd0);
        end
        bus_ready = 1'b1;
        mid();
        chk("t3_gnt_resume", {24'd0, gnt}, 32'h80);
        cyc();
        chk("t3_data", bus_data, 32'h107);
        chk("t3_src", {29'd0, bus_src}, 32'd7);

        // Wrap-around: win 6 so pointer becomes 7, then 6 and 0 compete
        req = 8'h40;
        mid();
        chk("t4_gnt6", {24'd0, gnt}, 32'h40);
        cyc();
        req = 8'h41;
        mid();
        chk("t4_gnt_wrap", {24'd0, gnt}, 32'h01);
        chk("t4_sel_wrap", {29'd0, sel}, 32'd0);
        cyc();
        chk("t4_ptr", {29'd0, dut.rr_ptr_q}, 32'd1);
        chk("t4_src", {29'd0, bus_src}, 32'd0);

        // Drain to empty
        req = 8'h00;
        cyc();
        chk("t5_valid_empty", {31'd0, bus_valid}, 32'd0);
        chk("t5_data_kept", bus_data, 32'h100);

        // Reset while holding a word and requesting
        req = 8'h10;
        cyc();
        chk("t5_valid_full", {31'd0, bus_valid}, 32'd1);
        chk("t5_data4", bus_data, 32'h104);
        reset_n = 1'b0;
        mid();
        chk("t5_gnt_rst", {24'd0, gnt}, 32'd0);
        chk("t5_sel_rst", {29'd0, sel}, 32'd0);
        cyc();
        chk("t5_valid_rst", {31'd0, bus_valid}, 32'd0);
        chk("t5_ptr_rst", {29'd0, dut.rr_ptr_q}, 32'd0);
        reset_n = 1'b1;
        req     = 8'h00;
        cyc();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
